branch_pattern_table: RTL and testbench

BRANCH_PATTERN_TABLE -- requirements
Module: branch_pattern_table

---
 rtl/branch_pattern_table.sv | 96 +++++++++
 tb/tb_branch_pattern_table.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/branch_pattern_table.sv
// Branch pattern table: DEPTH saturating counters indexed by PC (bimodal) or
// PC xor global history (gshare), self-initialised to weakly-not-taken after reset.
module branch_pattern_table #(
  parameter int CTR_W         = 2,
  parameter int IDX_W         = 6,
  parameter int GHR_W         = 6,
  parameter int MODE          = 0,
  parameter int STRONG_ON_HIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic [31:0]      pred_pc,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  output logic             ready
);

  localparam int unsigned      DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] SNT   = '0;
  localparam logic [CTR_W-1:0] ST    = '1;
  localparam logic [CTR_W-1:0] WNT   = {1'b0, {(CTR_W-1){1'b1}}};

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           state;
  logic [IDX_W-1:0] init_ptr;
  logic [GHR_W-1:0] ghr;
  logic [CTR_W-1:0] ctr_tbl [DEPTH];

  logic [IDX_W-1:0] ghr_ext;
  logic [CTR_W-1:0] upd_ctr;
  logic [CTR_W-1:0] upd_next;
  logic             upd_hit;
  logic             upd_accept;
  logic [GHR_W:0]   ghr_shift;
  logic             unused_bits;

  // Prediction path is purely combinational; a same-cycle update is not bypassed.
  always_comb begin
    ghr_ext = '0;
    if (MODE == 1) ghr_ext[GHR_W-1:0] = ghr;
    pred_idx   = pred_pc[IDX_W+1:2] ^ ghr_ext;
    pred_taken = ctr_tbl[pred_idx][CTR_W-1];
  end

  always_comb begin
    upd_accept = upd_valid && !stall && ready;
    upd_ctr    = ctr_tbl[upd_idx];
    upd_hit    = (upd_ctr[CTR_W-1] == upd_taken);
    ghr_shift  = {ghr, upd_taken};
    if ((STRONG_ON_HIT != 0) && upd_hit)
      upd_next = upd_taken ? ST : SNT;
    else if (upd_taken)
      upd_next = (upd_ctr == ST) ? upd_ctr : upd_ctr + CTR_W'(1);
    else
      upd_next = (upd_ctr == SNT) ? upd_ctr : upd_ctr - CTR_W'(1);
  end

  assign unused_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0], ghr_shift[GHR_W]};

  // INIT sweeps every entry once regardless of stall; updates only land in RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_INIT;
      init_ptr <= '0;
      ghr      <= '0;
      ready    <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          ctr_tbl[init_ptr] <= WNT;
          init_ptr          <= init_ptr + IDX_W'(1);
          if (&init_ptr) begin
            state <= S_RUN;
            ready <= 1'b1;
          end
        end
        S_RUN: begin
          if (upd_accept) begin
            ctr_tbl[upd_idx] <= upd_next;
            if (MODE == 1) ghr <= ghr_shift[GHR_W-1:0];
          end
        end
        default: begin
          state <= S_INIT;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_pattern_table.sv
// Directed bench for branch_pattern_table: three instances cover bimodal/strong,
// bimodal/step-by-one and gshare/strong with 2-bit counters and 16 entries.
module tb_branch_pattern_table;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall;
  logic [31:0] pc0, pc1, pc2;
  logic        uv0, uv1, uv2;
  logic [3:0]  ui0, ui1, ui2;
  logic        ut0, ut1, ut2;
  logic        pt0, pt1, pt2;
  logic [3:0]  pi0, pi1, pi2;
  logic        rdy0, rdy1, rdy2;

  int checks = 0;
  int errors = 0;

  bit out33 [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  bit exp33 [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  bit out35 [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [3:0] idx35 [4] = '{4'h5, 4'h6, 4'h1, 4'hF};

  branch_pattern_table #(.CTR_W(2), .IDX_W(4), .GHR_W(4), .MODE(0), .STRONG_ON_HIT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pred_pc(pc0), .pred_taken(pt0), .pred_idx(pi0),
    .upd_valid(uv0), .upd_idx(ui0), .upd_taken(ut0), .ready(rdy0));

  branch_pattern_table #(.CTR_W(2), .IDX_W(4), .GHR_W(4), .MODE(0), .STRONG_ON_HIT(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pred_pc(pc1), .pred_taken(pt1), .pred_idx(pi1),
    .upd_valid(uv1), .upd_idx(ui1), .upd_taken(ut1), .ready(rdy1));

  branch_pattern_table #(.CTR_W(2), .IDX_W(4), .GHR_W(4), .MODE(1), .STRONG_ON_HIT(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pred_pc(pc2), .pred_taken(pt2), .pred_idx(pi2),
    .upd_valid(uv2), .upd_idx(ui2), .upd_taken(ut2), .ready(rdy2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0;
    pc0 = '0; pc1 = '0; pc2 = '0;
    uv0 = 1'b0; uv1 = 1'b0; uv2 = 1'b0;
    ui0 = '0; ui1 = '0; ui2 = '0;
    ut0 = 1'b0; ut1 = 1'b0; ut2 = 1'b0;

    // Reset and initialisation sweep
    tick;
    chk("rst_ready", {29'd0, rdy0, rdy1, rdy2}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("init_ready_low", {29'd0, rdy0, rdy1, rdy2}, 32'd0);
      tick;
    end
    chk("ready_up", {29'd0, rdy0, rdy1, rdy2}, 32'd7);
    for (int i = 0; i < 16; i++) begin
      pc0 = 32'(i) << 2; pc1 = 32'(i) << 2; pc2 = 32'(i) << 2;
      #1;
      chk("init_pred0", pt0, 0);
      chk("init_idx0", pi0, 32'(i));
      chk("init_pred1", pt1, 0);
      chk("init_pred2", pt2, 0);
    end

    // Strong-on-hit on index 3
    pc0 = 32'h0C;
    #1;
    chk("strong_pred_start", pt0, exp33[0]);
    for (int j = 0; j < 4; j++) begin
      uv0 = 1'b1; ui0 = 4'd3; ut0 = out33[j];
      tick;
      uv0 = 1'b0;
      #1;
      chk("strong_pred", pt0, exp33[j+1]);
    end

    // Step-by-one saturation on index 5
    pc1 = 32'h14;
    #1;
    chk("sat_idx", pi1, 32'd5);
    for (int j = 0; j < 6; j++) begin
      uv1 = 1'b1; ui1 = 4'd5; ut1 = 1'b1;
      tick;
      uv1 = 1'b0;
      #1;
      chk("sat_taken", pt1, 1);
    end
    uv1 = 1'b1; ut1 = 1'b0;
    tick;
    chk("sat_nt_first", pt1, 1);
    tick;
    uv1 = 1'b0;
    #1;
    chk("sat_nt_second", pt1, 0);

    // gshare history build-up, then stalled replay
    pc2 = 32'h10;
    #1;
    chk("ghr_idx_start", pi2, 32'd4);
    for (int j = 0; j < 4; j++) begin
      uv2 = 1'b1; ui2 = 4'd0; ut2 = out35[j];
      tick;
      uv2 = 1'b0;
      #1;
      chk("ghr_idx", pi2, 32'(idx35[j]));
    end
    pc2 = 32'h2C;
    #1;
    chk("ghr_idx0", pi2, 32'd0);
    chk("ghr_ctr0", pt2, 1);
    stall = 1'b1;
    for (int j = 0; j < 4; j++) begin
      uv2 = 1'b1; ui2 = 4'd0; ut2 = out35[j];
      tick;
      chk("stall_idx", pi2, 32'd0);
      chk("stall_ctr", pt2, 1);
    end
    uv2 = 1'b0; stall = 1'b0;
    pc2 = 32'h10;
    #1;
    chk("stall_ghr_hold", pi2, 32'hF);

    // Same-cycle predict and update, no bypass
    pc0 = 32'h1C; uv0 = 1'b1; ui0 = 4'd7; ut0 = 1'b1;
    #1;
    chk("nobypass_same", pt0, 0);
    tick;
    uv0 = 1'b0;
    #1;
    chk("nobypass_next", pt0, 1);

    // Train index 2 then reset during RUN; held not-taken updates must be ignored
    pc0 = 32'h08; uv0 = 1'b1; ui0 = 4'd2; ut0 = 1'b1;
    tick;
    tick;
    chk("train_idx2", pt0, 1);
    rst_n = 1'b0; ut0 = 1'b0;
    tick;
    chk("rerst_ready", rdy0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("reinit_ready_low", rdy0, 0);
      tick;
    end
    chk("reinit_ready_up", rdy0, 1);
    uv0 = 1'b0;
    #1;
    chk("reinit_idx2", pt0, 0);
    uv0 = 1'b1; ut0 = 1'b1;
    tick;
    uv0 = 1'b0;
    #1;
    chk("reinit_idx2_wnt", pt0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
